// File: rtl/fetch_pc_select_dreg.sv
// Fetch-stage glue for the pipelined Y86-64 core: holds the F register (predicted PC),
// selects the PC presented to fetch, and captures fetch results into the D register.
// A two-state FSM stops fetching after a halt, illegal or address-error instruction and
// resumes on the next mispredict or ret redirect.
module fetch_pc_select_dreg #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [3:0]  RNONE    = 4'hF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // Fetched instruction fields, combinational in o_pc_val
  input  logic [3:0]  i_f_icode,
  input  logic [3:0]  i_f_ifun,
  input  logic [3:0]  i_f_rA,
  input  logic [3:0]  i_f_rB,
  input  logic [63:0] i_f_valC,
  input  logic [63:0] i_f_valP,
  input  logic        i_f_instr_valid,
  input  logic        i_f_mem_error,
  // Later-stage redirect sources
  input  logic [3:0]  i_M_icode,
  input  logic        i_M_cnd,
  input  logic [63:0] i_M_valA,
  input  logic [3:0]  i_W_icode,
  input  logic [63:0] i_W_valM,
  // Hazard-unit controls
  input  logic        i_F_stall,
  input  logic        i_D_stall,
  input  logic        i_D_bubble,
  // Fetch PC and pipeline register contents
  output logic [63:0] o_pc_val,
  output logic [63:0] o_F_predPC,
  output logic [3:0]  o_D_icode,
  output logic [3:0]  o_D_ifun,
  output logic [3:0]  o_D_rA,
  output logic [3:0]  o_D_rB,
  output logic [63:0] o_D_valC,
  output logic [63:0] o_D_valP,
  output logic [2:0]  o_D_stat,
  output logic        o_fetch_stopped
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [0:0] {
    StFetching,
    StStopped
  } state_e;

  state_e      r_state;
  state_e      w_state_next;

  logic        w_mispredict;
  logic        w_ret;
  logic        w_redirect;
  logic        w_fetching;
  logic        w_d_load;

  logic [63:0] w_f_predPC;
  logic [2:0]  w_f_stat;
  logic [3:0]  w_f_icode_eff;
  logic [3:0]  w_f_ifun_eff;
  logic [3:0]  w_f_rA_eff;
  logic [3:0]  w_f_rB_eff;

  logic [63:0] r_F_predPC;
  logic [3:0]  r_D_icode;
  logic [3:0]  r_D_ifun;
  logic [3:0]  r_D_rA;
  logic [3:0]  r_D_rB;
  logic [63:0] r_D_valC;
  logic [63:0] r_D_valP;
  logic [2:0]  r_D_stat;

  // Redirect sources: a not-taken jXX in M outranks a ret completing in W.
  always_comb begin
    w_mispredict = (i_M_icode == IJXX) && !i_M_cnd;
    w_ret        = (i_W_icode == IRET);
    w_redirect   = w_mispredict || w_ret;
    if (w_mispredict) begin
      o_pc_val = i_M_valA;
    end else if (w_ret) begin
      o_pc_val = i_W_valM;
    end else begin
      o_pc_val = r_F_predPC;
    end
  end

  // Decode fetch results: next-PC prediction, status and the fields D will capture.
  always_comb begin
    w_f_predPC = ((i_f_icode == IJXX) || (i_f_icode == ICALL)) ? i_f_valC : i_f_valP;

    if (i_f_mem_error) begin
      w_f_stat = SADR;
    end else if (!i_f_instr_valid) begin
      w_f_stat = SINS;
    end else if (i_f_icode == IHALT) begin
      w_f_stat = SHLT;
    end else begin
      w_f_stat = SAOK;
    end

    // An address error carries no real instruction, so it travels down as a NOP.
    w_f_icode_eff = i_f_mem_error ? INOP : i_f_icode;
    w_f_ifun_eff  = i_f_mem_error ? 4'h0 : i_f_ifun;

    // Instructions without register operands present RNONE so hazard logic sees no use.
    if ((w_f_icode_eff == IHALT) || (w_f_icode_eff == INOP) || (w_f_icode_eff == IJXX) ||
        (w_f_icode_eff == ICALL) || (w_f_icode_eff == IRET)) begin
      w_f_rA_eff = RNONE;
      w_f_rB_eff = RNONE;
    end else begin
      w_f_rA_eff = i_f_rA;
      w_f_rB_eff = i_f_rB;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StFetching;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: stop once a non-AOK instruction actually enters D; a redirect restarts.
  always_comb begin
    w_state_next = r_state;
    if (w_fetching) begin
      if (w_d_load && (w_f_stat != SAOK)) begin
        w_state_next = StStopped;
      end else begin
        w_state_next = StFetching;
      end
    end
  end

  // FSM outputs: a redirect while stopped is fetched and captured in the same cycle.
  always_comb begin
    w_fetching      = (r_state == StFetching) || w_redirect;
    w_d_load        = w_fetching && !i_D_stall && !i_D_bubble;
    o_fetch_stopped = (r_state == StStopped);
  end

  // F register: advances only while fetching and not stalled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_F_predPC <= RESET_PC;
    end else if (!i_F_stall && w_fetching) begin
      r_F_predPC <= w_f_predPC;
    end
  end

  // D register: stall holds, bubble or stopped fetch inserts a NOP, otherwise capture.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_D_icode <= INOP;
      r_D_ifun  <= 4'h0;
      r_D_rA    <= RNONE;
      r_D_rB    <= RNONE;
      r_D_valC  <= 64'd0;
      r_D_valP  <= 64'd0;
      r_D_stat  <= SAOK;
    end else if (i_D_stall) begin
      r_D_icode <= r_D_icode;
    end else if (w_d_load) begin
      r_D_icode <= w_f_icode_eff;
      r_D_ifun  <= w_f_ifun_eff;
      r_D_rA    <= w_f_rA_eff;
      r_D_rB    <= w_f_rB_eff;
      r_D_valC  <= i_f_valC;
      r_D_valP  <= i_f_valP;
      r_D_stat  <= w_f_stat;
    end else begin
      r_D_icode <= INOP;
      r_D_ifun  <= 4'h0;
      r_D_rA    <= RNONE;
      r_D_rB    <= RNONE;
      r_D_valC  <= 64'd0;
      r_D_valP  <= 64'd0;
      r_D_stat  <= SAOK;
    end
  end

  assign o_F_predPC = r_F_predPC;
  assign o_D_icode  = r_D_icode;
  assign o_D_ifun   = r_D_ifun;
  assign o_D_rA     = r_D_rA;
  assign o_D_rB     = r_D_rB;
  assign o_D_valC   = r_D_valC;
  assign o_D_valP   = r_D_valP;
  assign o_D_stat   = r_D_stat;

endmodule
